// File: rtl/pipelined_csel_subtractor_16bit.sv
// Pipelined carry-select subtractor: diff = a + ~b + 1,
// one SLICE-bit slice resolved per stage, valid/ready streaming.
module pipelined_csel_subtractor_16bit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSTG = WIDTH / SLICE;
  localparam int LST  = NSTG - 1;
  localparam int MSB  = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] pd;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rnb;
    logic             cy;
  } stg_t;

  stg_t            st [NSTG];
  stg_t            nx [NSTG];
  logic [NSTG-1:0] vld;
  logic [NSTG-1:0] adv;

  function automatic logic [SLICE:0] add_sl(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             c
  );
    add_sl = {1'b0, x} + {1'b0, y}
           + {{SLICE{1'b0}}, c};
  endfunction

  // A stage advances unless it and everything below it is full
  // and the output is blocked.
  always_comb begin : flow
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = LST; k >= 0; k--) begin
      full   = full & vld[k];
      adv[k] = out_ready | ~full;
    end
  end

  assign in_ready = rst_n & adv[0];

  always_comb begin : slices
    logic [SLICE:0] r0;
    logic [SLICE:0] r1;
    r0 = add_sl(a[SLICE-1:0], ~b[SLICE-1:0], 1'b1);
    r1 = r0;
    nx[0]                  = '0;
    nx[0].ra               = a;
    nx[0].rnb              = ~b;
    nx[0].pd[SLICE-1:0]    = r0[SLICE-1:0];
    nx[0].cy               = r0[SLICE];
    for (int k = 1; k < NSTG; k++) begin
      r0 = add_sl(st[k-1].ra[k*SLICE +: SLICE],
                  st[k-1].rnb[k*SLICE +: SLICE], 1'b0);
      r1 = add_sl(st[k-1].ra[k*SLICE +: SLICE],
                  st[k-1].rnb[k*SLICE +: SLICE], 1'b1);
      nx[k] = st[k-1];
      if (st[k-1].cy) begin
        nx[k].pd[k*SLICE +: SLICE] = r1[SLICE-1:0];
        nx[k].cy                   = r1[SLICE];
      end else begin
        nx[k].pd[k*SLICE +: SLICE] = r0[SLICE-1:0];
        nx[k].cy                   = r0[SLICE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < NSTG; k++) st[k] <= '0;
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        if (in_valid) st[0] <= nx[0];
      end
      for (int k = 1; k < NSTG; k++) begin
        if (adv[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) st[k] <= nx[k];
        end
      end
    end
  end

  assign out_valid  = vld[LST];
  assign diff       = st[LST].pd;
  assign borrow_out = vld[LST] & ~st[LST].cy;
  assign overflow   = vld[LST]
                    & (st[LST].ra[MSB] ^ ~st[LST].rnb[MSB])
                    & (st[LST].pd[MSB] ^ st[LST].ra[MSB]);
  assign zero       = vld[LST] & ~|st[LST].pd;

endmodule

// File: tb/tb_pipelined_csel_subtractor_16bit.sv
// Bench for the pipelined subtractor: directed and random
// streams against an arithmetic reference queue.
module tb_pipelined_csel_subtractor_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  pipelined_csel_subtractor_16bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          npop = 0;
  logic        last_ov = 1'b0;
  logic        last_ir = 1'b0;
  logic [15:0] last_d = '0;
  logic        stall_prev = 1'b0;
  logic [19:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x,
                                 input logic [15:0] y);
    exp_t e;
    int   sd;
    e.d  = x - y;
    e.bo = (x < y);
    sd   = int'($signed(x)) - int'($signed(y));
    e.ov = (sd > 32767) || (sd < -32768);
    e.z  = (x == y);
    return e;
  endfunction

  task automatic tick(input logic iv, input logic [15:0] ia,
                      input logic [15:0] ib, input logic ordy);
    exp_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    @(negedge clk);
    last_ov = out_valid;
    last_ir = in_ready;
    if (stall_prev)
      chk("hold", {out_valid, borrow_out, overflow, zero, diff}, held);
    stall_prev = out_valid && !out_ready;
    held = {out_valid, borrow_out, overflow, zero, diff};
    if (in_valid && in_ready) q.push_back(model(a, b));
    if (out_valid && out_ready) begin
      npop++;
      if (q.size() == 0) begin
        chk("spurious", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("borrow", borrow_out, e.bo);
        chk("ovf", overflow, e.ov);
        chk("zero", zero, e.z);
        last_d = diff;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) tick(0, 0, 0, 1);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_ov", out_valid, 0);
    chk("rst_d", diff, 0);
    chk("rst_bo", borrow_out, 0);
    chk("rst_of", overflow, 0);
    chk("rst_z", zero, 0);
    chk("rst_ir", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ir_up", in_ready, 1);

    tick(1, 16'h1234, 16'h0234, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1);
      chk("lat_early", last_ov, 0);
    end
    tick(0, 0, 0, 1);
    chk("lat4", last_ov, 1);
    chk("d1000", last_d, 16'h1000);

    tick(1, 16'h0000, 16'h0001, 1);
    tick(1, 16'hBEEF, 16'hBEEF, 1);
    tick(1, 16'h8000, 16'h0001, 1);
    tick(1, 16'h7FFF, 16'hFFFF, 1);
    tick(1, 16'hFFFF, 16'h0000, 1);
    tick(1, 16'h0010, 16'h0001, 1);
    drain();

    npop = 0;
    for (int i = 0; i < 8; i++)
      tick(1, 16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
    chk("stream_cnt", npop, 8);
    drain();

    for (int i = 0; i < 6; i++) begin
      tick(1, 16'($urandom), 16'($urandom), 0);
      chk("bp_ir", last_ir, (i < 4));
    end
    chk("bp_ov", out_valid, 1);
    drain();

    for (int i = 0; i < 5; i++)
      tick(1, 16'($urandom), 16'($urandom), 0);
    chk("full_ov", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ov", out_valid, 0);
    chk("mid_ir", in_ready, 0);
    chk("mid_d", diff, 0);
    q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    npop = 0;
    for (int i = 0; i < 3; i++)
      tick(1, 16'($urandom), 16'($urandom), 1);
    drain();
    chk("post_rst_cnt", npop, 3);

    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
